// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: AluOP codes, MIPS opcode/funct
// values and the EX pipeline register layout with its bubble value.
package alu_pkg;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRA  = 4'b0001;
    localparam logic [3:0] ALU_SRL  = 4'b0010;
    localparam logic [3:0] ALU_MULU = 4'b0011;
    localparam logic [3:0] ALU_DIVU = 4'b0100;
    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shamt;
        logic        illegal;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{valid: 1'b0, aluop: ALU_ADD, a: 32'd0,
                                      b: 32'd0, shamt: 5'd0, illegal: 1'b0};

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS decode into AluOP, operand A/B and shamt; flags
// undecodable words and the slow multiply/divide ops.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  aluop,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  shamt,
    output logic        illegal,
    output logic        is_md
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  sa;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign sa     = instr[10:6];
    assign imm_sx = {{16{instr[15]}}, instr[15:0]};
    assign imm_zx = {16'd0, instr[15:0]};

    always_comb begin
        aluop   = ALU_ADD;
        a       = rs_data;
        b       = rt_data;
        shamt   = 5'd0;
        illegal = 1'b0;
        is_md   = 1'b0;
        if (opcode == OP_RTYPE) begin
            unique case (funct)
                FN_SLL:            begin aluop = ALU_SLL; shamt = sa; end
                FN_SRL:            begin aluop = ALU_SRL; shamt = sa; end
                // Arithmetic shifts take the distance on A, not shamt.
                FN_SRA:            begin aluop = ALU_SRA; a = {27'd0, sa}; end
                FN_SRAV:           begin aluop = ALU_SRA; a = {27'd0, rs_data[4:0]}; end
                FN_MULTU:          begin aluop = ALU_MULU; is_md = 1'b1; end
                FN_DIVU:           begin aluop = ALU_DIVU; is_md = 1'b1; end
                FN_ADD, FN_ADDU:   aluop = ALU_ADD;
                FN_SUB, FN_SUBU:   aluop = ALU_SUB;
                FN_AND:            aluop = ALU_AND;
                FN_OR:             aluop = ALU_OR;
                FN_XOR:            aluop = ALU_XOR;
                FN_NOR:            aluop = ALU_NOR;
                FN_SLT:            aluop = ALU_SLT;
                FN_SLTU:           aluop = ALU_SLTU;
                default:           illegal = 1'b1;
            endcase
        end else begin
            unique case (opcode)
                OP_ADDI, OP_ADDIU,
                OP_LW, OP_SW:      begin aluop = ALU_ADD;  b = imm_sx; end
                OP_SLTI:           begin aluop = ALU_SLT;  b = imm_sx; end
                OP_SLTIU:          begin aluop = ALU_SLTU; b = imm_sx; end
                OP_ANDI:           begin aluop = ALU_AND;  b = imm_zx; end
                OP_ORI:            begin aluop = ALU_OR;   b = imm_zx; end
                OP_XORI:           begin aluop = ALU_XOR;  b = imm_zx; end
                OP_LUI:            begin aluop = ALU_SLL;  b = imm_zx; shamt = 5'd16; end
                OP_BEQ, OP_BNE:    aluop = ALU_SUB;
                default:           illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            aluop = ALU_ADD;
            a     = 32'd0;
            b     = 32'd0;
            shamt = 5'd0;
            is_md = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register feeding the ALU, with flush/stall handling and a
// residency counter that holds MULTU/DIVU in EX for MD_CYCLES cycles.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [3:0]  ex_aluop,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_shamt,
    output logic        ex_illegal,
    output logic        ex_md_busy
);

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    ex_reg_t    ex_q, ex_d, dec;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       dec_is_md;

    alu_op_decode u_decode (
        .instr   (id_instr),
        .rs_data (id_rs_data),
        .rt_data (id_rt_data),
        .aluop   (dec.aluop),
        .a       (dec.a),
        .b       (dec.b),
        .shamt   (dec.shamt),
        .illegal (dec.illegal),
        .is_md   (dec_is_md)
    );
    assign dec.valid = id_valid;

    // Valid/ready: an ID word transfers on a posedge where id_valid and
    // id_ready are both high and flush is low; flush drops it silently.
    assign ex_md_busy = (md_cnt_q != 4'd0);
    assign id_ready   = rst_n & ~ex_stall & ~ex_md_busy;

    always_comb begin
        ex_d     = ex_q;
        md_cnt_d = md_cnt_q;
        if (flush) begin
            ex_d     = EX_BUBBLE;
            md_cnt_d = 4'd0;
        end else if (ex_md_busy) begin
            // The hold ignores ex_stall so residency is exactly MD_CYCLES.
            md_cnt_d = md_cnt_q - 4'd1;
        end else if (!ex_stall) begin
            if (id_valid) begin
                ex_d     = dec;
                md_cnt_d = dec_is_md ? MD_LOAD : 4'd0;
            end else begin
                ex_d = EX_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q     <= EX_BUBBLE;
            md_cnt_q <= 4'd0;
        end else begin
            ex_q     <= ex_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_aluop   = ex_q.aluop;
    assign ex_a       = ex_q.a;
    assign ex_b       = ex_q.b;
    assign ex_shamt   = ex_q.shamt;
    assign ex_illegal = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed plan steps then random traffic, all
// checked against a behavioural model of the EX slot and md residency.
module tb_alu_issue_stage;

    localparam int MD_CYCLES = 4;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_stall;
    logic        flush;
    logic        id_ready;
    logic        ex_valid;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_shamt;
    logic        ex_illegal;
    logic        ex_md_busy;

    int n_checks = 0;
    int n_fails  = 0;

    // Model of what EX should hold, and how many more cycles an md op stays.
    logic        m_valid;
    logic [3:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [4:0]  m_sh;
    logic        m_ill;
    int          m_left;

    alu_issue_stage #(.MD_CYCLES(MD_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .ex_stall   (ex_stall),
        .flush      (flush),
        .id_ready   (id_ready),
        .ex_valid   (ex_valid),
        .ex_aluop   (ex_aluop),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_shamt   (ex_shamt),
        .ex_illegal (ex_illegal),
        .ex_md_busy (ex_md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode straight from the instruction-set table.
    task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                              output logic [3:0] op, output logic [31:0] a, output logic [31:0] b,
                              output logic [4:0] sh, output logic ill, output logic md);
        logic [31:0] sx, zx;
        sx = {{16{ins[15]}}, ins[15:0]};
        zx = {16'd0, ins[15:0]};
        op = 4'd5; a = rs; b = rt; sh = 5'd0; ill = 1'b0; md = 1'b0;
        if (ins[31:26] == 6'h00) begin
            case (ins[5:0])
                6'h00: begin op = 4'd0; sh = ins[10:6]; end
                6'h02: begin op = 4'd2; sh = ins[10:6]; end
                6'h03: begin op = 4'd1; a = 32'(ins[10:6]); end
                6'h07: begin op = 4'd1; a = rs & 32'h1F; end
                6'h19: begin op = 4'd3; md = 1'b1; end
                6'h1B: begin op = 4'd4; md = 1'b1; end
                6'h20, 6'h21: op = 4'd5;
                6'h22, 6'h23: op = 4'd6;
                6'h24: op = 4'd7;
                6'h25: op = 4'd8;
                6'h26: op = 4'd9;
                6'h27: op = 4'd10;
                6'h2A: op = 4'd11;
                6'h2B: op = 4'd12;
                default: ill = 1'b1;
            endcase
        end else begin
            case (ins[31:26])
                6'h08, 6'h09, 6'h23, 6'h2B: begin op = 4'd5; b = sx; end
                6'h0A: begin op = 4'd11; b = sx; end
                6'h0B: begin op = 4'd12; b = sx; end
                6'h0C: begin op = 4'd7; b = zx; end
                6'h0D: begin op = 4'd8; b = zx; end
                6'h0E: begin op = 4'd9; b = zx; end
                6'h0F: begin op = 4'd0; b = zx; sh = 5'd16; end
                6'h04, 6'h05: op = 4'd6;
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            op = 4'd5; a = 32'd0; b = 32'd0; sh = 5'd0; md = 1'b0;
        end
    endtask

    task automatic set_bubble();
        m_valid = 1'b0; m_op = 4'd5; m_a = 32'd0; m_b = 32'd0; m_sh = 5'd0; m_ill = 1'b0;
    endtask

    // One cycle: drive inputs, check id_ready, clock, update model, check EX.
    task automatic step(input logic rst_v, input logic v, input logic [31:0] ins,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic st, input logic fl);
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic        ill, md;
        rst_n = rst_v; id_valid = v; id_instr = ins; id_rs_data = rs; id_rt_data = rt;
        ex_stall = st; flush = fl;
        #1;
        check("id_ready", 32'(id_ready), 32'(rst_v && !st && m_left == 0));
        ref_decode(ins, rs, rt, op, a, b, sh, ill, md);
        @(posedge clk);
        if (!rst_v || fl) begin
            set_bubble();
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (!st) begin
            if (v) begin
                m_valid = 1'b1; m_op = op; m_a = a; m_b = b; m_sh = sh; m_ill = ill;
                m_left = md ? MD_CYCLES - 1 : 0;
            end else begin
                set_bubble();
            end
        end
        #1;
        check("ex_valid", 32'(ex_valid), 32'(m_valid));
        check("ex_aluop", 32'(ex_aluop), 32'(m_op));
        check("ex_a", ex_a, m_a);
        check("ex_b", ex_b, m_b);
        check("ex_shamt", 32'(ex_shamt), 32'(m_sh));
        check("ex_illegal", 32'(ex_illegal), 32'(m_ill));
        check("ex_md_busy", 32'(ex_md_busy), 32'(m_left != 0));
    endtask

    localparam logic [31:0] I_ADD   = 32'h00851020;
    localparam logic [31:0] I_ADDI  = 32'h2008FFFF;
    localparam logic [31:0] I_ORI   = 32'h3408FFFF;
    localparam logic [31:0] I_LUI   = 32'h3C081234;
    localparam logic [31:0] I_SRA   = 32'h00021903;
    localparam logic [31:0] I_MULTU = 32'h00850019;
    localparam logic [31:0] I_SUB   = 32'h00851022;
    localparam logic [31:0] I_BAD   = 32'hFC000000;

    logic [11:0] legal_tbl [0:28];

    initial begin
        int busy_cycles;
        int waited;
        logic [31:0] ins;
        legal_tbl = '{12'h000, 12'h002, 12'h003, 12'h007, 12'h019, 12'h01B, 12'h020,
                      12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
                      12'h02A, 12'h02B, 12'h200, 12'h240, 12'h280, 12'h2C0, 12'h300,
                      12'h340, 12'h380, 12'h3C0, 12'h100, 12'h140, 12'h8C0, 12'hAC0,
                      12'hFC0};
        m_left = 0;
        set_bubble();

        // Reset with a valid ADD presented.
        step(0, 1, I_ADD, 32'd7, 32'd9, 0, 0);
        step(0, 1, I_ADD, 32'd7, 32'd9, 0, 0);
        check("rst_aluop_lit", 32'(ex_aluop), 32'h5);
        check("rst_valid_lit", 32'(ex_valid), 32'h0);

        step(1, 1, I_ADDI, 32'd5, 32'd1, 0, 0);
        check("addi_b_lit", ex_b, 32'hFFFF_FFFF);
        step(1, 1, I_ORI, 32'd3, 32'd1, 0, 0);
        check("ori_b_lit", ex_b, 32'h0000_FFFF);
        step(1, 1, I_LUI, 32'hDEAD_BEEF, 32'd1, 0, 0);
        check("lui_shamt_lit", 32'(ex_shamt), 32'd16);
        step(1, 1, I_SRA, 32'h55, 32'h8000_0000, 0, 0);
        check("sra_a_lit", ex_a, 32'd4);

        // MULTU with id_valid held: count busy cycles, then next op lands.
        step(1, 1, I_MULTU, 32'd6, 32'd7, 0, 0);
        busy_cycles = 0;
        waited = 0;
        while (ex_md_busy && waited < 20) begin
            busy_cycles++;
            waited++;
            step(1, 1, I_SUB, 32'd10, 32'd3, 0, 0);
        end
        check("multu_busy_len", 32'(busy_cycles), 32'd3);
        step(1, 1, I_SUB, 32'd10, 32'd3, 0, 0);
        check("after_multu_op", 32'(ex_aluop), 32'h6);

        // Same with a stall pulsed mid-hold: residency must not stretch.
        step(1, 1, I_MULTU, 32'd6, 32'd7, 0, 0);
        step(1, 1, I_SUB, 32'd10, 32'd3, 1, 0);
        step(1, 1, I_SUB, 32'd10, 32'd3, 0, 0);
        check("stall_hold_busy", 32'(ex_md_busy), 32'd1);
        step(1, 1, I_SUB, 32'd10, 32'd3, 0, 0);
        check("stall_hold_done", 32'(ex_md_busy), 32'd0);
        step(1, 1, I_ADD, 32'd1, 32'd2, 0, 0);

        // Stall freezes EX; flush under stall loads a bubble.
        for (int i = 0; i < 3; i++) step(1, 1, I_LUI, 32'd1, 32'd2, 1, 0);
        check("stall_frozen_a", ex_a, 32'd1);
        step(1, 1, I_LUI, 32'd1, 32'd2, 1, 1);
        check("flush_stall_valid", 32'(ex_valid), 32'd0);

        // Illegal opcode, then flush in the middle of a MULTU hold.
        step(1, 1, I_BAD, 32'd8, 32'd9, 0, 0);
        check("illegal_flag_lit", 32'(ex_illegal), 32'd1);
        step(1, 1, I_MULTU, 32'd6, 32'd7, 0, 0);
        step(1, 1, I_ADD, 32'd6, 32'd7, 0, 0);
        step(1, 1, I_ADD, 32'd6, 32'd7, 0, 1);
        check("flush_md_busy", 32'(ex_md_busy), 32'd0);
        // Reset in the middle of a hold.
        step(1, 1, I_MULTU, 32'd6, 32'd7, 0, 0);
        step(0, 1, I_ADD, 32'd6, 32'd7, 0, 0);
        check("rst_md_busy", 32'(ex_md_busy), 32'd0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                logic [11:0] t;
                t = legal_tbl[$urandom_range(0, 28)];
                ins[31:26] = t[11:6];
                if (t[11:6] == 6'h00) ins[5:0] = t[5:0];
            end
            step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0, ins, $urandom, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
